// File: rtl/prbs_chk_par.sv
// Purpose   : self-synchronising PRBS31 (x^31+x^28+1) checker for DW-bit parallel words
// Latency   : DIN sampled at edge k is checked at edge k+1 (counters, LOCKED, FRAME_DONE)
// Backpress.: none, accepts one word per cycle
//
// Ports:
//   CLK, RST         rising-edge clock, async active-high reset
//   CLR              synchronous clear of all state and outputs
//   ALIGNED, DIPUSH  a word is taken only when both are high
//   DIN              received word, bit 0 earliest on the line
//   FRAME_MODE, INIT 1 = count only inside the INIT-opened window of FRAME_LEN words
//   LOCKED           lock state (HUNT=0, LOCKED=1)
//   ERR_CNT/RECV_CNT saturating bit-error and counted-word totals
//   LOSS_CNT         saturating count of lock losses
//   FRAME_DONE       one-cycle pulse when the frame window closes
module prbs_chk_par #(
    parameter int DW         = 16,
    parameter int CW         = 64,
    parameter int FRAME_LEN  = 1024,
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_CNT = 4,
    parameter int BAD_THR    = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          CLR,
    input  logic          ALIGNED,
    input  logic          DIPUSH,
    input  logic [DW-1:0] DIN,
    input  logic          FRAME_MODE,
    input  logic          INIT,
    output logic          LOCKED,
    output logic [CW-1:0] ERR_CNT,
    output logic [CW-1:0] RECV_CNT,
    output logic [15:0]   LOSS_CNT,
    output logic          FRAME_DONE
);

    localparam int EW          = $clog2(DW + 1);
    localparam int CW1         = CW + 1;
    localparam int PRIME_WORDS = (31 + DW - 1) / DW;
    localparam int PW          = $clog2(PRIME_WORDS + 1);
    localparam int GW          = $clog2(LOCK_CNT + 1);
    localparam int BW          = $clog2(UNLOCK_CNT + 1);
    localparam int WW          = $clog2(FRAME_LEN + 1);
    // a threshold at or above DW can never be exceeded; clamp so it fits EW bits
    localparam int BT          = (BAD_THR > DW) ? DW : BAD_THR;

    localparam logic [PW-1:0] PRIME_DONE = PW'(PRIME_WORDS);
    localparam logic [GW-1:0] GOOD_LAST  = GW'(LOCK_CNT - 1);
    localparam logic [BW-1:0] BAD_LAST   = BW'(UNLOCK_CNT - 1);
    localparam logic [WW-1:0] WIN_LOAD   = WW'(FRAME_LEN);
    localparam logic [EW-1:0] BAD_LIM    = EW'(BT);

    localparam logic [0:0] ST_HUNT   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    // state
    logic [DW-1:0] din_d1_q,     din_d1_d;
    logic          valid_d1_q,   valid_d1_d;
    logic [30:0]   hist_q,       hist_d;
    logic [PW-1:0] prime_cnt_q,  prime_cnt_d;
    logic [0:0]    state_q,      state_d;
    logic [GW-1:0] good_run_q,   good_run_d;
    logic [BW-1:0] bad_run_q,    bad_run_d;
    logic [WW-1:0] win_cnt_q,    win_cnt_d;
    logic [CW-1:0] err_cnt_q,    err_cnt_d;
    logic [CW-1:0] recv_cnt_q,   recv_cnt_d;
    logic [15:0]   loss_cnt_q,   loss_cnt_d;
    logic          frame_done_q, frame_done_d;

    // stage-2 datapath
    logic [DW+30:0] stream;
    logic [DW-1:0]  exp_bits;
    logic [DW-1:0]  diff;
    logic [EW-1:0]  err_word;
    logic [CW:0]    err_sum;
    logic           valid_in;
    logic           primed;
    logic           checked;
    logic           word_good;
    logic           word_bad;
    logic           candidate;
    logic           win_open;
    logic           count_en;

    assign valid_in = DIPUSH & ALIGNED;

    // stream[0] is the oldest history bit (n-31 relative to din_d1[0]), so
    // expected bit i = stream[i] ^ stream[i+3]. For DW>28 the upper taps reach
    // into din_d1 itself, which is what makes the checker self-synchronising.
    assign stream = {din_d1_q, hist_q};

    always_comb begin
        exp_bits = '0;
        for (int i = 0; i < DW; i++) begin
            exp_bits[i] = stream[i] ^ stream[i+3];
        end
    end

    assign diff = din_d1_q ^ exp_bits;

    always_comb begin
        err_word = '0;
        for (int i = 0; i < DW; i++) begin
            err_word = err_word + EW'(diff[i]);
        end
    end

    assign primed    = (prime_cnt_q == PRIME_DONE);
    assign checked   = valid_d1_q & primed;
    assign word_good = (err_word == '0);
    assign word_bad  = (err_word > BAD_LIM);
    assign candidate = checked & (state_q == ST_LOCKED);
    assign win_open  = (win_cnt_q != '0);
    // INIT on the same edge as a word reloads the window and swallows that word
    assign count_en  = candidate & (FRAME_MODE ? (win_open & ~INIT) : 1'b1);
    assign err_sum   = {1'b0, err_cnt_q} + CW1'(err_word);

    always_comb begin
        din_d1_d     = valid_in ? DIN : din_d1_q;
        valid_d1_d   = valid_in;
        hist_d       = hist_q;
        prime_cnt_d  = prime_cnt_q;
        state_d      = state_q;
        good_run_d   = good_run_q;
        bad_run_d    = bad_run_q;
        win_cnt_d    = win_cnt_q;
        err_cnt_d    = err_cnt_q;
        recv_cnt_d   = recv_cnt_q;
        loss_cnt_d   = loss_cnt_q;
        frame_done_d = 1'b0;

        // history always tracks received bits, whatever the lock state
        if (valid_d1_q) begin
            hist_d = stream[DW+30:DW];
            if (!primed) begin
                prime_cnt_d = prime_cnt_q + PW'(1);
            end
        end

        if (checked) begin
            if (state_q == ST_HUNT) begin
                if (word_good) begin
                    if (good_run_q == GOOD_LAST) begin
                        state_d    = ST_LOCKED;
                        good_run_d = '0;
                        bad_run_d  = '0;
                    end else begin
                        good_run_d = good_run_q + GW'(1);
                    end
                end else begin
                    good_run_d = '0;
                end
            end else begin
                if (word_bad) begin
                    if (bad_run_q == BAD_LAST) begin
                        state_d    = ST_HUNT;
                        good_run_d = '0;
                        bad_run_d  = '0;
                        loss_cnt_d = (&loss_cnt_q) ? loss_cnt_q : loss_cnt_q + 16'd1;
                    end else begin
                        bad_run_d = bad_run_q + BW'(1);
                    end
                end else begin
                    bad_run_d = '0;
                end
            end
        end

        // window decrements on every checked word, hunting or locked
        if (INIT) begin
            win_cnt_d = WIN_LOAD;
        end else if (checked && win_open) begin
            win_cnt_d = win_cnt_q - WW'(1);
        end
        frame_done_d = win_open & (win_cnt_d == '0);

        if (count_en) begin
            recv_cnt_d = (&recv_cnt_q) ? recv_cnt_q : recv_cnt_q + CW'(1);
            err_cnt_d  = err_sum[CW] ? {CW{1'b1}} : err_sum[CW-1:0];
        end

        if (CLR) begin
            din_d1_d     = '0;
            valid_d1_d   = 1'b0;
            hist_d       = '0;
            prime_cnt_d  = '0;
            state_d      = ST_HUNT;
            good_run_d   = '0;
            bad_run_d    = '0;
            win_cnt_d    = '0;
            err_cnt_d    = '0;
            recv_cnt_d   = '0;
            loss_cnt_d   = '0;
            frame_done_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            din_d1_q     <= '0;
            valid_d1_q   <= 1'b0;
            hist_q       <= '0;
            prime_cnt_q  <= '0;
            state_q      <= ST_HUNT;
            good_run_q   <= '0;
            bad_run_q    <= '0;
            win_cnt_q    <= '0;
            err_cnt_q    <= '0;
            recv_cnt_q   <= '0;
            loss_cnt_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            din_d1_q     <= din_d1_d;
            valid_d1_q   <= valid_d1_d;
            hist_q       <= hist_d;
            prime_cnt_q  <= prime_cnt_d;
            state_q      <= state_d;
            good_run_q   <= good_run_d;
            bad_run_q    <= bad_run_d;
            win_cnt_q    <= win_cnt_d;
            err_cnt_q    <= err_cnt_d;
            recv_cnt_q   <= recv_cnt_d;
            loss_cnt_q   <= loss_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign LOCKED     = (state_q == ST_LOCKED);
    assign ERR_CNT    = err_cnt_q;
    assign RECV_CNT   = recv_cnt_q;
    assign LOSS_CNT   = loss_cnt_q;
    assign FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_prbs_chk_par.sv
// Directed bench for prbs_chk_par: main instance (DW=16, CW=64, LOCK_CNT=4)
// plus a CW=8 instance with BAD_THR=DW for counter saturation.
module tb_prbs_chk_par;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr = 1'b0;
    logic        aligned = 1'b0;
    logic        dipush = 1'b0;
    logic [15:0] din = '0;
    logic        frame_mode = 1'b0;
    logic        init = 1'b0;
    logic        locked;
    logic [63:0] err_cnt;
    logic [63:0] recv_cnt;
    logic [15:0] loss_cnt;
    logic        frame_done;

    logic        b_clr = 1'b0;
    logic        b_aligned = 1'b0;
    logic        b_dipush = 1'b0;
    logic [15:0] b_din = '0;
    logic        b_fm = 1'b0;
    logic        b_init = 1'b0;
    logic        b_locked;
    logic [7:0]  b_err;
    logic [7:0]  b_recv;
    logic [15:0] b_loss;
    logic        b_done;

    int          n_checks = 0;
    int          n_fail = 0;
    int          done_pulses = 0;
    logic [30:0] g;
    logic [30:0] gb;
    logic [15:0] w;

    always #5 clk = ~clk;

    prbs_chk_par #(.DW(16), .CW(64), .FRAME_LEN(1024), .LOCK_CNT(4), .UNLOCK_CNT(4), .BAD_THR(4)) dut (
        .CLK(clk), .RST(rst), .CLR(clr), .ALIGNED(aligned), .DIPUSH(dipush), .DIN(din),
        .FRAME_MODE(frame_mode), .INIT(init), .LOCKED(locked), .ERR_CNT(err_cnt),
        .RECV_CNT(recv_cnt), .LOSS_CNT(loss_cnt), .FRAME_DONE(frame_done)
    );

    prbs_chk_par #(.DW(16), .CW(8), .FRAME_LEN(4), .LOCK_CNT(4), .UNLOCK_CNT(4), .BAD_THR(16)) dut_sat (
        .CLK(clk), .RST(rst), .CLR(b_clr), .ALIGNED(b_aligned), .DIPUSH(b_dipush), .DIN(b_din),
        .FRAME_MODE(b_fm), .INIT(b_init), .LOCKED(b_locked), .ERR_CNT(b_err),
        .RECV_CNT(b_recv), .LOSS_CNT(b_loss), .FRAME_DONE(b_done)
    );

    always @(negedge clk) begin
        if (frame_done === 1'b1) done_pulses++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // PRBS31 stimulus source: s[0] is the oldest bit, new bit = s[0]^s[3]
    task automatic prbs_word(inout logic [30:0] s, output logic [15:0] wo);
        logic b;
        wo = '0;
        for (int i = 0; i < 16; i++) begin
            b = s[0] ^ s[3];
            wo[i] = b;
            s = {b, s[30:1]};
        end
    endtask

    task automatic push(input logic [15:0] v);
        @(negedge clk);
        din = v; dipush = 1'b1; aligned = 1'b1; init = 1'b0;
    endtask

    task automatic push_init(input logic [15:0] v);
        @(negedge clk);
        din = v; dipush = 1'b1; aligned = 1'b1; init = 1'b1;
    endtask

    task automatic push_unaligned(input logic [15:0] v);
        @(negedge clk);
        din = v; dipush = 1'b1; aligned = 1'b0; init = 1'b0;
    endtask

    task automatic flush();
        @(negedge clk);
        dipush = 1'b0; init = 1'b0;
        @(negedge clk);
    endtask

    task automatic push_b(input logic [15:0] v);
        @(negedge clk);
        b_din = v; b_dipush = 1'b1; b_aligned = 1'b1;
    endtask

    task automatic flush_b();
        @(negedge clk);
        b_dipush = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b want 0", locked); end
        n_checks++; if (err_cnt !== 64'd0) begin n_fail++; $display("FAIL reset_err: got %0d want 0", err_cnt); end
        n_checks++; if (recv_cnt !== 64'd0) begin n_fail++; $display("FAIL reset_recv: got %0d want 0", recv_cnt); end
        n_checks++; if (loss_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_loss: got %0d want 0", loss_cnt); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", frame_done); end
    endtask

    // words 1-2 prime, 3-6 lock (LOCKED at word 6, not counted), 7-100 counted
    task automatic test_lock_acquire();
        g = 31'h2A3B4C5D;
        for (int i = 1; i <= 5; i++) begin prbs_word(g, w); push(w); end
        flush();
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_early: LOCKED=%b want 0 after word 5", locked); end
        prbs_word(g, w); push(w);
        flush();
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_w6: LOCKED=%b want 1 after word 6", locked); end
        n_checks++; if (recv_cnt !== 64'd0) begin n_fail++; $display("FAIL lock_word_uncounted: RECV=%0d want 0", recv_cnt); end
        for (int i = 7; i <= 100; i++) begin
            if (i == 50) push_unaligned(16'hFFFF);
            prbs_word(g, w); push(w);
        end
        flush();
        n_checks++; if (recv_cnt !== 64'd94) begin n_fail++; $display("FAIL clean_recv: RECV=%0d want 94", recv_cnt); end
        n_checks++; if (err_cnt !== 64'd0) begin n_fail++; $display("FAIL clean_err: ERR=%0d want 0", err_cnt); end
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL clean_locked: LOCKED=%b want 1", locked); end
    endtask

    // one flipped bit -> itself plus echoes at +28 and +31
    task automatic test_single_flip();
        prbs_word(g, w); push(w ^ 16'h0020);
        for (int i = 0; i < 3; i++) begin prbs_word(g, w); push(w); end
        flush();
        n_checks++; if (err_cnt !== 64'd3) begin n_fail++; $display("FAIL flip_err: ERR=%0d want 3", err_cnt); end
        n_checks++; if (recv_cnt !== 64'd98) begin n_fail++; $display("FAIL flip_recv: RECV=%0d want 98", recv_cnt); end
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL flip_locked: LOCKED=%b want 1", locked); end
        n_checks++; if (loss_cnt !== 16'd0) begin n_fail++; $display("FAIL flip_loss: LOSS=%0d want 0", loss_cnt); end
    endtask

    // four inverted words give 16,13,16,16 errors; resume gives 0,3,0,0,0,0
    task automatic test_unlock_relock();
        for (int i = 0; i < 3; i++) begin prbs_word(g, w); push(~w); end
        flush();
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL unlock_early: LOCKED=%b want 1 after 3 bad", locked); end
        prbs_word(g, w); push(~w);
        flush();
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL unlock_w4: LOCKED=%b want 0", locked); end
        n_checks++; if (loss_cnt !== 16'd1) begin n_fail++; $display("FAIL unlock_loss: LOSS=%0d want 1", loss_cnt); end
        n_checks++; if (err_cnt !== 64'd64) begin n_fail++; $display("FAIL unlock_err: ERR=%0d want 64", err_cnt); end
        n_checks++; if (recv_cnt !== 64'd102) begin n_fail++; $display("FAIL unlock_recv: RECV=%0d want 102", recv_cnt); end
        for (int i = 0; i < 5; i++) begin prbs_word(g, w); push(w); end
        flush();
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL relock_early: LOCKED=%b want 0", locked); end
        prbs_word(g, w); push(w);
        flush();
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL relock: LOCKED=%b want 1", locked); end
        n_checks++; if (recv_cnt !== 64'd102) begin n_fail++; $display("FAIL hunt_uncounted: RECV=%0d want 102", recv_cnt); end
        prbs_word(g, w); push(w);
        flush();
        n_checks++; if (recv_cnt !== 64'd103) begin n_fail++; $display("FAIL relock_recv: RECV=%0d want 103", recv_cnt); end
    endtask

    // window restart by INIT coincident with word 10: words 1-9 plus 1024 counted
    task automatic test_frame_window();
        int base;
        @(negedge clk);
        frame_mode = 1'b1;
        for (int i = 0; i < 3; i++) begin prbs_word(g, w); push(w); end
        flush();
        n_checks++; if (recv_cnt !== 64'd103) begin n_fail++; $display("FAIL closed_window: RECV=%0d want 103", recv_cnt); end
        base = done_pulses;
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        for (int i = 1; i <= 1100; i++) begin
            prbs_word(g, w);
            if (i == 11) push_init(w); else push(w);
        end
        flush();
        n_checks++; if (recv_cnt !== 64'd1136) begin n_fail++; $display("FAIL frame_recv: RECV=%0d want 1136", recv_cnt); end
        n_checks++; if (done_pulses - base != 1) begin n_fail++; $display("FAIL frame_done_pulses: got %0d want 1", done_pulses - base); end
        n_checks++; if (err_cnt !== 64'd64) begin n_fail++; $display("FAIL frame_err: ERR=%0d want 64", err_cnt); end
        frame_mode = 1'b0;
    endtask

    // CLR with a word in stage 1; relock needs full re-prime (2) + 4
    task automatic test_clr();
        prbs_word(g, w); push(w);
        @(negedge clk);
        dipush = 1'b0; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL clr_locked: LOCKED=%b want 0", locked); end
        n_checks++; if (recv_cnt !== 64'd0) begin n_fail++; $display("FAIL clr_recv: RECV=%0d want 0", recv_cnt); end
        n_checks++; if (err_cnt !== 64'd0) begin n_fail++; $display("FAIL clr_err: ERR=%0d want 0", err_cnt); end
        n_checks++; if (loss_cnt !== 16'd0) begin n_fail++; $display("FAIL clr_loss: LOSS=%0d want 0", loss_cnt); end
        for (int i = 0; i < 5; i++) begin prbs_word(g, w); push(w); end
        flush();
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL clr_reprime: LOCKED=%b want 0", locked); end
        prbs_word(g, w); push(w);
        flush();
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL clr_relock: LOCKED=%b want 1", locked); end
        prbs_word(g, w); push(w);
        flush();
        n_checks++; if (recv_cnt !== 64'd1) begin n_fail++; $display("FAIL clr_recount: RECV=%0d want 1", recv_cnt); end
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL arst_locked: LOCKED=%b want 0", locked); end
        n_checks++; if (recv_cnt !== 64'd0) begin n_fail++; $display("FAIL arst_recv: RECV=%0d want 0", recv_cnt); end
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_saturation();
        gb = 31'h01234567;
        for (int i = 0; i < 6; i++) begin prbs_word(gb, w); push_b(w); end
        flush_b();
        n_checks++; if (b_locked !== 1'b1) begin n_fail++; $display("FAIL sat_lock: LOCKED=%b want 1", b_locked); end
        for (int i = 0; i < 100; i++) push_b(16'hFFFF);
        flush_b();
        n_checks++; if (b_recv !== 8'd100) begin n_fail++; $display("FAIL sat_recv_mid: RECV=%0d want 100", b_recv); end
        n_checks++; if (b_err !== 8'd255) begin n_fail++; $display("FAIL sat_err_mid: ERR=%0d want 255", b_err); end
        for (int i = 0; i < 200; i++) push_b(16'hFFFF);
        flush_b();
        n_checks++; if (b_recv !== 8'd255) begin n_fail++; $display("FAIL sat_recv: RECV=%0d want 255", b_recv); end
        n_checks++; if (b_err !== 8'd255) begin n_fail++; $display("FAIL sat_err: ERR=%0d want 255", b_err); end
        n_checks++; if (b_locked !== 1'b1) begin n_fail++; $display("FAIL sat_locked: LOCKED=%b want 1", b_locked); end
    endtask

    initial begin
        test_reset();
        test_lock_acquire();
        test_single_flip();
        test_unlock_relock();
        test_frame_window();
        test_clr();
        test_async_reset();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prbs_chk_par.md
# prbs_chk_par

Parametrised, self-synchronising PRBS31 checker for the parallel receive path. It sits after the word aligner and takes DW-bit words qualified by push and alignment flags. It hunts for and tracks lock, and counts bit errors and received words in saturating counters. The checker runs either continuously or over INIT-triggered frames of FRAME_LEN words.

## Interface
Parameters:
- DW, 16: data word width; legal range 8..64.
- CW, 64: width of ERR_CNT and RECV_CNT.
- FRAME_LEN, 1024: words counted per frame in frame mode; legal range ≥1.
- LOCK_CNT, 16: consecutive error-free checked words needed to acquire lock.
- UNLOCK_CNT, 4: consecutive bad words needed to drop lock.
- BAD_THR, 4: a word is bad when its bit-error count is > BAD_THR.

Ports:
- CLK in 1: clock; all logic is rising-edge.
- RST in 1: asynchronous, active-high reset.
- CLR in 1: synchronous clear of all state and outputs; highest priority after RST.
- ALIGNED in 1: word alignment valid.
- DIPUSH in 1: DIN valid this cycle.
- DIN in DW: received word; bit 0 is the earliest bit on the line.
- FRAME_MODE in 1: 1 = count only inside the INIT window; 0 = continuous. Must be static while the window is open.
- INIT in 1: one-cycle pulse; opens or restarts the frame window.
- LOCKED out 1: lock state.
- ERR_CNT out CW: saturating total of bit errors.
- RECV_CNT out CW: saturating total of counted words.
- LOSS_CNT out 16: saturating count of LOCKED→HUNT transitions.
- FRAME_DONE out 1: one-cycle pulse when the frame window closes.

## Operation
- Valid word: DIPUSH & ALIGNED. Words with ALIGNED=0 are ignored completely.
- Stage 1 registers each valid word as din_d1 and valid_d1. Stage 2 checks din_d1.
- History: hist[30:0] holds the last 31 received bits. It is updated with every stage-2 word in every state. Received bits, not expected bits, feed it.
- Expected bit n = r[n-31] ^ r[n-28], where r is the received stream formed by concatenating {din_d1, hist}. When DW>28, bits within the same word feed later expected bits.
- err_word = popcount(din_d1 ^ expected), width clog2(DW+1).
- Primed: asserted once ceil(31/DW) words have passed through stage 2 since reset/CLR. Only words arriving when already primed are "checked".
- Lock FSM, states HUNT (reset) and LOCKED:
  - HUNT: a checked word with err_word=0 increments good_run; any error clears good_run. At good_run = LOCK_CNT, go to LOCKED and clear both runs.
  - LOCKED: each checked word is a counting candidate. A bad word increments bad_run; a non-bad word clears it. At bad_run = UNLOCK_CNT, go to HUNT, increment LOSS_CNT and clear both runs.
  - The word that achieves lock is not counted. The word that causes unlock is counted.
- Counting: a candidate is counted when FRAME_MODE=0, or when FRAME_MODE=1 and the window is open.
  - Each counted word adds 1 to RECV_CNT and err_word to ERR_CNT.
  - Both counters saturate at all-ones and never wrap.
- Frame window:
  - win_cnt is loaded with FRAME_LEN on an edge where INIT=1.
  - It decrements on each stage-2 checked word while nonzero; the window is open while win_cnt≠0. Hunting words decrement it but are not counted.
  - If INIT coincides with a stage-2 word, INIT wins and that word is neither counted nor decremented.
  - INIT during an open window restarts the window.
  - FRAME_DONE pulses for one cycle on the 1→0 transition of win_cnt, in both modes.
- CLR clears stage 1, hist, primed, the FSM (to HUNT), the runs, win_cnt and all outputs.

## Timing
- Reset/CLR values: LOCKED=0, ERR_CNT=0, RECV_CNT=0, LOSS_CNT=0, FRAME_DONE=0, hist=0, win_cnt=0.
- DIN sampled at edge k is checked at edge k+1; counters, LOCKED and FRAME_DONE change at k+1. Latency is 2 edges from DIN to visible count.
- Full throughput: one word per cycle, no backpressure.
- RST asserted mid-frame takes effect immediately and asynchronously. CLR takes effect at the next edge and discards any word in stage 1.
- When ERR_CNT and RECV_CNT saturate on the same edge, both hold at all-ones independently.

## Test plan
- DW=16, LOCK_CNT=4, clean PRBS31 stream, FRAME_MODE=0: words 1–2 prime; words 3–6 lock. LOCKED rises at stage-2 edge of word 6. After 100 words: RECV_CNT=94, ERR_CNT=0.
- Locked; flip one bit of one word: ERR_CNT=3 (the flipped bit plus self-sync echoes at +28 and +31), LOCKED stays 1, LOSS_CNT=0.
- Locked; UNLOCK_CNT=4; push 4 all-ones words (16 errors each once hist is all-ones): LOCKED drops at the 4th word, LOSS_CNT=1. Then resume PRBS: relock after hist refill (2 words) plus 4 good words.
- FRAME_MODE=1, FRAME_LEN=1024: lock, pulse INIT, push 1100 words → RECV_CNT=1024, FRAME_DONE exactly one pulse. INIT coincident with a word → that word not counted.
- CW=8, continuous errored locked stream with BAD_THR=DW: ERR_CNT reaches 255 and holds; RECV_CNT saturates at 255.
- CLR mid-stream while locked → next cycle all outputs 0, LOCKED=0. RST pulsed asynchronously between edges → outputs clear immediately.
